// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU.
// PC-source encodings, fetch FSM states and the reset PC.
package cpu_pkg;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_REG    = 2'd3;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      FETCH_IDLE,
      FETCH_BUSY
   } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source select and word-alignment check.
// Purely combinational; the top applies the result on pc_en.
module pc_next_mux
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [1:0]        pc_src_i,
   input  logic [ADDR_W-1:0] alu_result_i,
   input  logic [ADDR_W-1:0] alu_out_i,
   input  logic [ADDR_W-1:0] rf_read1_i,
   input  logic [3:0]        pc_hi_i,
   input  logic [25:0]       target26_i,
   output logic [ADDR_W-1:0] next_pc_o,
   output logic              misalign_o
);

   logic [ADDR_W-1:0] jump_tgt;

   assign jump_tgt = {pc_hi_i, target26_i, 2'b00};

   always_comb begin
      next_pc_o = alu_result_i;
      unique case (pc_src_i)
         PCSRC_ALU:    next_pc_o = alu_result_i;
         PCSRC_ALUOUT: next_pc_o = alu_out_i;
         PCSRC_JUMP:   next_pc_o = jump_tgt;
         PCSRC_REG:    next_pc_o = rf_read1_i;
         default:      next_pc_o = alu_result_i;
      endcase
   end

   assign misalign_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC and IR registers, imem req/ack fetch FSM,
// IR field decode and sticky misalign / fetch-overlap flags.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCWrite,
   input  logic              PCWriteCond,
   input  logic              branch_taken,
   input  logic [1:0]        PCSource,
   input  logic              IRWrite,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [ADDR_W-1:0] rf_read1,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       ir,
   output logic [5:0]        OP,
   output logic [5:0]        funct,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [15:0]       imm16,
   output logic              fetch_stall,
   output logic              misalign_err,
   output logic              fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [31:0]       ir_q, ir_d;
   logic              mis_q, mis_d;
   logic              ferr_q, ferr_d;
   logic [ADDR_W-1:0] next_pc;
   logic              next_mis;
   logic              pc_en;

   pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
      .pc_src_i     (PCSource),
      .alu_result_i (alu_result),
      .alu_out_i    (alu_out),
      .rf_read1_i   (rf_read1),
      .pc_hi_i      (pc_q[ADDR_W-1 -: 4]),
      .target26_i   (ir_q[25:0]),
      .next_pc_o    (next_pc),
      .misalign_o   (next_mis)
   );

   assign pc_en = PCWrite | (PCWriteCond & branch_taken);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      faddr_d  = faddr_q;
      ir_d     = ir_q;
      mis_d    = mis_q;
      ferr_d   = ferr_q;
      imem_req = 1'b0;
      unique case (state_q)
         FETCH_IDLE: begin
            if (pc_en) begin
               pc_d = {next_pc[ADDR_W-1:2], 2'b00};
               if (next_mis) mis_d = 1'b1;
            end
            if (IRWrite) begin
               faddr_d = pc_q;
               state_d = FETCH_BUSY;
            end
         end
         FETCH_BUSY: begin
            imem_req = 1'b1;
            if (IRWrite) ferr_d = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = FETCH_IDLE;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_IDLE;
         pc_q    <= RESET_PC;
         faddr_q <= '0;
         ir_q    <= '0;
         mis_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         faddr_q <= faddr_d;
         ir_q    <= ir_d;
         mis_q   <= mis_d;
         ferr_q  <= ferr_d;
      end
   end

   assign imem_addr    = faddr_q;
   assign fetch_stall  = (state_q == FETCH_BUSY);
   assign pc           = pc_q;
   assign ir           = ir_q;
   assign misalign_err = mis_q;
   assign fetch_err    = ferr_q;

   assign OP    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign funct = ir_q[5:0];
   assign imm16 = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        PCWrite, PCWriteCond, branch_taken;
   logic [1:0]  PCSource;
   logic        IRWrite;
   logic [31:0] alu_result, alu_out, rf_read1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc, ir;
   logic [5:0]  OP, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic        fetch_stall, misalign_err, fetch_err;

   int n_chk;
   int n_pass;
   int stall_cnt;

   instr_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCWrite      (PCWrite),
      .PCWriteCond  (PCWriteCond),
      .branch_taken (branch_taken),
      .PCSource     (PCSource),
      .IRWrite      (IRWrite),
      .alu_result   (alu_result),
      .alu_out      (alu_out),
      .rf_read1     (rf_read1),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .ir           (ir),
      .OP           (OP),
      .funct        (funct),
      .rs           (rs),
      .rt           (rt),
      .rd           (rd),
      .shamt        (shamt),
      .imm16        (imm16),
      .fetch_stall  (fetch_stall),
      .misalign_err (misalign_err),
      .fetch_err    (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      branch_taken = 1'b0;
      PCSource     = 2'd0;
      IRWrite      = 1'b0;
      imem_ack     = 1'b0;
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      idle_inputs();
      alu_result = '0;
      alu_out    = '0;
      rf_read1   = '0;
      imem_rdata = '0;
      rst_n      = 1'b0;
      #12;
      check("rst_pc", pc, 32'h0);
      check("rst_ir", ir, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_stall", {31'b0, fetch_stall}, 32'h0);
      check("rst_errs", {30'b0, misalign_err, fetch_err}, 32'h0);
      rst_n = 1'b1;
      step();

      // sequential fetch, ack on third BUSY cycle
      IRWrite    = 1'b1;
      PCWrite    = 1'b1;
      PCSource   = 2'd0;
      alu_result = 32'h4;
      step();
      idle_inputs();
      check("seq_pc", pc, 32'h4);
      check("seq_addr", imem_addr, 32'h0);
      check("seq_req", {31'b0, imem_req}, 32'h1);
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (fetch_stall) stall_cnt++;
         if (stall_cnt == 3) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h2009_0005;
         end
         step();
         imem_ack = 1'b0;
         if (!fetch_stall) break;
      end
      check("seq_stall_cyc", stall_cnt, 32'd3);
      check("seq_ir", ir, 32'h2009_0005);
      check("seq_op", {26'b0, OP}, 32'h08);
      check("seq_rt", {27'b0, rt}, 32'd9);
      check("seq_rs", {27'b0, rs}, 32'd0);
      check("seq_imm", {16'b0, imm16}, 32'h5);

      // conditional branch
      PCWriteCond  = 1'b1;
      PCSource     = 2'd1;
      alu_out      = 32'h40;
      branch_taken = 1'b0;
      step();
      check("br_nt_pc", pc, 32'h4);
      branch_taken = 1'b1;
      step();
      idle_inputs();
      check("br_t_pc", pc, 32'h40);

      // set pc, then zero-wait fetch of a J instruction
      PCWrite    = 1'b1;
      alu_result = 32'h1000_0004;
      step();
      idle_inputs();
      check("setpc", pc, 32'h1000_0004);
      IRWrite = 1'b1;
      step();
      IRWrite    = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0800_0010;
      check("zw_stall", {31'b0, fetch_stall}, 32'h1);
      check("zw_addr", imem_addr, 32'h1000_0004);
      check("zw_ir_old", ir, 32'h2009_0005);
      step();
      imem_ack = 1'b0;
      check("zw_ir", ir, 32'h0800_0010);
      check("zw_stall_off", {31'b0, fetch_stall}, 32'h0);

      // jump then JR with misaligned target
      PCWrite  = 1'b1;
      PCSource = 2'd2;
      step();
      check("j_pc", pc, 32'h1000_0040);
      check("j_mis", {31'b0, misalign_err}, 32'h0);
      PCSource = 2'd3;
      rf_read1 = 32'h0000_0123;
      step();
      idle_inputs();
      check("jr_pc", pc, 32'h120);
      check("jr_mis", {31'b0, misalign_err}, 32'h1);

      // stall protection
      IRWrite = 1'b1;
      step();
      PCWrite    = 1'b1;
      PCSource   = 2'd0;
      alu_result = 32'h80;
      IRWrite    = 1'b1;
      step();
      idle_inputs();
      check("sp_pc", pc, 32'h120);
      check("sp_ferr", {31'b0, fetch_err}, 32'h1);
      check("sp_addr", imem_addr, 32'h120);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      check("sp_ir", ir, 32'h1234_5678);
      check("sp_req_off", {31'b0, imem_req}, 32'h0);
      step();
      check("sp_no_req2", {31'b0, imem_req}, 32'h0);
      check("sp_pc_hold", pc, 32'h120);

      // reset mid-BUSY, then late ack
      IRWrite = 1'b1;
      step();
      IRWrite = 1'b0;
      check("rb_req", {31'b0, imem_req}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rb_pc", pc, 32'h0);
      check("rb_ir", ir, 32'h0);
      check("rb_req_off", {31'b0, imem_req}, 32'h0);
      check("rb_errs", {30'b0, misalign_err, fetch_err}, 32'h0);
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      check("late_ack_ir", ir, 32'h0);
      check("late_ack_req", {31'b0, imem_req}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the multicycle control unit. Owns the PC register and the instruction register (IR), and issues fetches to instruction memory over a req/ack handshake with variable latency.
- Decodes IR fields (op, funct, rs, rt, rd, shamt, imm16, target26) and presents them, with the current PC, to the control unit and datapath.
- Applies the control unit's PC-write, PC-source and IR-write strobes. Raises a stall while a fetch is outstanding so the control FSM holds its state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and imem address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCWrite  in  1  unconditional PC load strobe.
- PCWriteCond  in  1  conditional PC load, qualified by branch_taken.
- branch_taken  in  1  branch comparison result from the branch unit.
- PCSource  in  2  next-PC select: 0 alu_result, 1 alu_out, 2 jump target, 3 rf_read1.
- IRWrite  in  1  start an instruction fetch at the current PC.
- alu_result  in  32  combinational ALU output (PC+4 path).
- alu_out  in  32  registered ALU output (branch target).
- rf_read1  in  32  register-file port 1 (JR/JALR target).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  one-cycle data-valid pulse from imem.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  current PC.
- ir  out  32  instruction register.
- OP  out  6  ir[31:26].
- funct  out  6  ir[5:0].
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- shamt  out  5  ir[10:6].
- imm16  out  16  ir[15:0].
- fetch_stall  out  1  fetch outstanding; the control unit must hold its state.
- misalign_err  out  1  sticky: a PC target with [1:0]!=0 was loaded.
- fetch_err  out  1  sticky: IRWrite was asserted while a fetch was outstanding.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ir=0, fetch state IDLE.
  - imem_req=0, fetch_stall=0, both error flags 0.
  - Reset mid-fetch abandons the fetch; a late imem_ack after reset is ignored in IDLE.
- pc_en = PCWrite | (PCWriteCond & branch_taken).
- Next-PC mux:
  - 0: alu_result.
  - 1: alu_out.
  - 2: {pc[31:28], ir[25:0], 2'b00}.
  - 3: rf_read1.
- When pc_en=1, PC loads next_pc[31:2] with the low bits forced to 00. If next_pc[1:0]!=0, misalign_err sets and stays set until reset.
- Fetch FSM, two states:
  - IDLE: IRWrite=1 captures fetch_addr<=pc (the pre-update PC) and moves to BUSY. A simultaneous pc_en in the same cycle still updates the PC (the PC+4 case).
  - BUSY: imem_req=1, imem_addr=fetch_addr, fetch_stall=1. On imem_ack: ir<=imem_rdata, return to IDLE.
- Latency: minimum 2 cycles from IRWrite to the new ir (ack arriving on the first BUSY cycle). fetch_stall is high from the cycle after IRWrite until the ack cycle inclusive.
- While in BUSY:
  - PCWrite, PCWriteCond and IRWrite are ignored; pc and ir hold.
  - IRWrite in BUSY sets fetch_err (sticky).
- imem_ack while IDLE is ignored.
- ir and the decoded fields hold between fetches. The fields are combinational slices of ir.
- No HALT handling here; HALT is decoded by the control unit.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSRC_ALU=0, PCSRC_ALUOUT=1, PCSRC_JUMP=2, PCSRC_REG=3.
  - Fetch state enum FETCH_IDLE / FETCH_BUSY.
  - RESET_PC default.
- One natural sub-module, pc_next_mux: the combinational 4:1 next-PC select plus the alignment check. The FSM, PC register and IR stay in the top.

Test Plan:
- Reset: rst_n=0 mid-BUSY -> pc=RESET_PC, ir=0, imem_req=0 immediately. A late imem_ack=1 with rdata=32'hDEADBEEF leaves ir=0.
- Sequential fetch: pc=0, IRWrite=1, PCWrite=1, PCSource=0, alu_result=4; imem acks 3 cycles later with 32'h2009_0005.
  - Expect imem_addr=0, pc=4.
  - fetch_stall high for 3 cycles.
  - ir=32'h2009_0005, OP=6'h08, rt=9, imm16=5.
- Branch: PCWriteCond=1, PCSource=1, alu_out=32'h40. branch_taken=0 -> pc unchanged; branch_taken=1 -> pc=32'h40.
- Jump and JR:
  - ir=32'h0800_0010, pc=32'h1000_0004, PCWrite=1, PCSource=2 -> pc=32'h1000_0040.
  - PCSource=3, rf_read1=32'h0000_0123 -> pc=32'h120, misalign_err=1.
- Stall protection: during BUSY, drive PCWrite=1, alu_result=32'h80 and IRWrite=1 -> pc unchanged, fetch_err=1, no second request after the ack.
- Zero-wait memory: imem_ack high on the first BUSY cycle -> ir updates 2 cycles after IRWrite, fetch_stall high exactly 1 cycle.
